// File: rtl/button_debouncer.sv
// Multi-channel 2-flop synchronizer + stability-counting debouncer for buttons/switches.
// Optional BUTTON_DEBOUNCER_EDGE_PULSE_EN adds registered one-cycle rise/fall pulses.
module button_debouncer #(
    parameter int unsigned WIDTH         = 3,
    parameter int unsigned STABLE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] y,
`ifdef BUTTON_DEBOUNCER_EDGE_PULSE_EN
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
`endif
    output logic [WIDTH-1:0] busy
);

    localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } state_t;

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_y;
    logic [WIDTH-1:0] r_busy;
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] r_fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_ch
        state_t        r_state;
        state_t        w_state_nxt;
        logic [CW-1:0] r_cnt;
        logic [CW-1:0] w_cnt_nxt;
        logic          w_done;

        // Acceptance fires on the edge that would bring cnt to STABLE_CYCLES, so y
        // lands exactly STABLE_CYCLES+1 edges after raw is first captured.
        assign w_done = (({1'b0, r_cnt} + 1'b1) >= (CW + 1)'(STABLE_CYCLES));

        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            case (r_state)
                STABLE_LO: begin
                    w_cnt_nxt = '0;
                    if (r_sync2[g]) begin
                        w_state_nxt = WAIT_HI;
                        w_cnt_nxt   = CW'(1);
                    end
                end
                WAIT_HI: begin
                    if (!r_sync2[g]) begin
                        w_state_nxt = STABLE_LO;
                        w_cnt_nxt   = '0;
                    end else if (w_done) begin
                        w_state_nxt = STABLE_HI;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end
                STABLE_HI: begin
                    w_cnt_nxt = '0;
                    if (!r_sync2[g]) begin
                        w_state_nxt = WAIT_LO;
                        w_cnt_nxt   = CW'(1);
                    end
                end
                WAIT_LO: begin
                    if (r_sync2[g]) begin
                        w_state_nxt = STABLE_HI;
                        w_cnt_nxt   = '0;
                    end else if (w_done) begin
                        w_state_nxt = STABLE_LO;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end
                default: begin
                    w_state_nxt = STABLE_LO;
                    w_cnt_nxt   = '0;
                end
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state   <= STABLE_LO;
                r_cnt     <= '0;
                r_y[g]    <= 1'b0;
                r_busy[g] <= 1'b0;
                r_rise[g] <= 1'b0;
                r_fall[g] <= 1'b0;
            end else begin
                r_state   <= w_state_nxt;
                r_cnt     <= w_cnt_nxt;
                r_y[g]    <= (w_state_nxt == STABLE_HI) || (w_state_nxt == WAIT_LO);
                r_busy[g] <= (w_state_nxt == WAIT_HI) || (w_state_nxt == WAIT_LO);
                r_rise[g] <= (r_state == WAIT_HI) && (w_state_nxt == STABLE_HI);
                r_fall[g] <= (r_state == WAIT_LO) && (w_state_nxt == STABLE_LO);
            end
        end
    end

    assign y    = r_y;
    assign busy = r_busy;

`ifdef BUTTON_DEBOUNCER_EDGE_PULSE_EN
    assign rise = r_rise;
    assign fall = r_fall;
`else
    logic w_unused_pulses;
    assign w_unused_pulses = ^{r_rise, r_fall};
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Randomized self-checking bench for button_debouncer (WIDTH=3, STABLE_CYCLES=4)
// against a run-length reference model.
module tb_button_debouncer;

    localparam int unsigned W = 3;
    localparam int unsigned S = 4;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] raw;
    logic [W-1:0] y;
    logic [W-1:0] busy;
`ifdef BUTTON_DEBOUNCER_EDGE_PULSE_EN
    logic [W-1:0] rise;
    logic [W-1:0] fall;
`endif

    button_debouncer #(.WIDTH(W), .STABLE_CYCLES(S)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (raw),
        .y     (y),
`ifdef BUTTON_DEBOUNCER_EDGE_PULSE_EN
        .rise  (rise),
        .fall  (fall),
`endif
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_cmp;
    int unsigned n_err;

    // Reference model: sync delay line plus, per channel, the length of the
    // current run of edges on which the synchronized level disagreed with y.
    logic [W-1:0] m_s1, m_s2, m_y, m_rise, m_fall;
    int unsigned  m_run [W];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] m_busy();
        logic [W-1:0] b;
        for (int i = 0; i < W; i++) b[i] = (m_run[i] != 0);
        return b;
    endfunction

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_y = '0; m_rise = '0; m_fall = '0;
        for (int i = 0; i < W; i++) m_run[i] = 0;
    endtask

    task automatic tick(input logic [W-1:0] r);
        raw = r;
        @(posedge clk);
        m_rise = '0;
        m_fall = '0;
        for (int i = 0; i < W; i++) begin
            if (m_s2[i] != m_y[i]) begin
                m_run[i]++;
                if (m_run[i] == S) begin
                    m_y[i]    = ~m_y[i];
                    m_rise[i] = m_y[i];
                    m_fall[i] = ~m_y[i];
                    m_run[i]  = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_s2 = m_s1;
        m_s1 = r;
        #1;
        check("y", 32'(y), 32'(m_y));
        check("busy", 32'(busy), 32'(m_busy()));
`ifdef BUTTON_DEBOUNCER_EDGE_PULSE_EN
        check("rise", 32'(rise), 32'(m_rise));
        check("fall", 32'(fall), 32'(m_fall));
`endif
    endtask

    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_y", 32'(y), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        raw   = '0;
        rst_n = 1'b0;
        model_reset();
        #12;
        check("por_y", 32'(y), 32'd0);
        check("por_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        #2;

        // Async reset from a settled all-high state
        repeat (8) tick(3'b111);
        check("settled_111", 32'(y), 32'h7);
        async_reset();

        // Clean rise on ch0
        repeat (8) tick(3'b000);
        for (int k = 0; k <= 6; k++) begin
            tick(3'b001);
            check("rise_y0", 32'(y[0]), 32'(k >= 5));
            check("rise_busy0", 32'(busy[0]), 32'(k >= 2 && k <= 4));
        end

        // Bounce 1,1,0,1 then held
        repeat (8) tick(3'b000);
        for (int k = 0; k <= 9; k++) begin
            tick((k == 2) ? 3'b000 : 3'b001);
            check("bounce_y0", 32'(y[0]), 32'(k >= 8));
        end

        // Single-cycle pulse is rejected
        repeat (8) tick(3'b000);
        tick(3'b001);
        for (int k = 0; k < 8; k++) begin
            tick(3'b000);
            check("pulse_y0", 32'(y[0]), 32'd0);
        end

        // Simultaneous transitions on ch1, ch2
        for (int k = 0; k <= 6; k++) begin
            tick(3'b110);
            check("simul_y", 32'(y), (k >= 5) ? 32'h6 : 32'h0);
            check("simul_busy0", 32'(busy[0]), 32'd0);
        end

        // Reset while ch2 is counting, then the full latency again
        repeat (8) tick(3'b000);
        for (int k = 0; k <= 4; k++) tick(3'b100);
        check("mid_run", m_run[2], 32'd3);
        async_reset();
        for (int k = 0; k <= 6; k++) begin
            tick(3'b100);
            check("after_rst_y2", 32'(y[2]), 32'(k >= 5));
        end

`ifdef BUTTON_DEBOUNCER_EDGE_PULSE_EN
        begin
            int unsigned n_r, n_f, n_other;
            n_r = 0; n_f = 0; n_other = 0;
            repeat (8) tick(3'b000);
            for (int k = 0; k < 16; k++) begin
                tick((k < 8) ? 3'b010 : 3'b000);
                n_r += rise[1];
                n_f += fall[1];
                n_other += rise[0] + rise[2] + fall[0] + fall[2];
            end
            check("rise1_count", n_r, 32'd1);
            check("fall1_count", n_f, 32'd1);
            check("other_pulses", n_other, 32'd0);
        end
`endif

        // Randomized bouncing inputs with occasional async resets
        begin
            logic [W-1:0] r;
            r = '0;
            for (int n = 0; n < 1500; n++) begin
                for (int i = 0; i < W; i++)
                    if ($urandom_range(7) == 0) r[i] = ~r[i];
                if ($urandom_range(199) == 0) async_reset();
                tick(r);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
